// File: rtl/seg7_scan_driver.sv
// Eight-digit multiplexed seven-segment scan driver.
// A prescaler sets the dwell time per digit; the digit data and display
// controls are captured once per frame so that the whole frame is shown
// from one consistent snapshot. All display outputs are active-low.
module seg7_scan_driver #(
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] digits,
    input  logic [7:0]  digit_en,
    input  logic [7:0]  dp_mask,
    input  logic        blank_lz,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        scan_tick
);

    localparam int unsigned PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);

    logic [PW-1:0] presc;
    logic          tick;
    logic [2:0]    index;

    logic [31:0]   snap_digits;
    logic [7:0]    snap_en;
    logic [7:0]    snap_dp;
    logic          snap_blz;
    logic          load_pending;

    logic [7:0]    lz_blank;
    logic [3:0]    cur_digit;
    logic          slot_dark;

    // Segment pattern for one hex digit, {g,f,e,d,c,b,a}, active-low.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    assign tick = (presc == PRESC_LAST);

    // Prescaler, scan index and the registered advance pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc     <= '0;
            index     <= '0;
            scan_tick <= 1'b0;
        end else begin
            scan_tick <= tick;
            if (tick) begin
                presc <= '0;
                index <= index + 3'd1;
            end else begin
                presc <= presc + 1'b1;
            end
        end
    end

    // Frame snapshot: captured on the first edge out of reset and at each
    // 7->0 wrap, so the next frame starts from freshly latched inputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            snap_digits  <= '0;
            snap_en      <= '0;
            snap_dp      <= '0;
            snap_blz     <= 1'b0;
            load_pending <= 1'b1;
        end else begin
            load_pending <= 1'b0;
            if (load_pending || (tick && index == 3'd7)) begin
                snap_digits <= digits;
                snap_en     <= digit_en;
                snap_dp     <= dp_mask;
                snap_blz    <= blank_lz;
            end
        end
    end

    // Leading-zero blanking, scanning from the most significant digit down;
    // digit 0 is always exempt so an all-zero value still shows a single 0.
    always_comb begin
        logic        zero_above;
        int unsigned i;
        lz_blank   = '0;
        zero_above = 1'b1;
        for (int unsigned k = 0; k < 8; k++) begin
            i          = 7 - k;
            zero_above = zero_above & (snap_digits[4*i +: 4] == 4'h0);
            lz_blank[i] = snap_blz && (i != 0) && zero_above;
        end
    end

    // Current slot's digit value and whether the slot is dark.
    always_comb begin
        cur_digit = snap_digits[{index, 2'b00} +: 4];
        slot_dark = lz_blank[index] || !snap_en[index];
    end

    // Registered display outputs, one cycle behind the scan index.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            an  <= '1;
            seg <= '1;
            dp  <= 1'b1;
        end else if (slot_dark) begin
            an  <= '1;
            seg <= '1;
            dp  <= 1'b1;
        end else begin
            an  <= ~(8'b1 << index);
            seg <= hex_to_seg(cur_digit);
            dp  <= ~snap_dp[index];
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed self-checking bench for seg7_scan_driver with REFRESH_DIV=4.
module tb_seg7_scan_driver;

    logic        clk;
    logic        reset;
    logic [31:0] digits;
    logic [7:0]  digit_en;
    logic [7:0]  dp_mask;
    logic        blank_lz;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        scan_tick;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // Expected per-slot display values for one frame.
    logic [7:0] e_an  [8];
    logic [6:0] e_seg [8];
    logic       e_dp  [8];

    logic       sync_prev_tick;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S6 = 7'b0000010;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] S8 = 7'b0000000;

    seg7_scan_driver #(.REFRESH_DIV(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .digits    (digits),
        .digit_en  (digit_en),
        .dp_mask   (dp_mask),
        .blank_lz  (blank_lz),
        .an        (an),
        .seg       (seg),
        .dp        (dp),
        .scan_tick (scan_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic set_lit(input int s, input logic [6:0] sv, input logic dv);
        e_an[s]  = ~(8'b1 << s);
        e_seg[s] = sv;
        e_dp[s]  = dv;
    endtask

    task automatic set_dark(input int s);
        e_an[s]  = 8'hFF;
        e_seg[s] = 7'h7F;
        e_dp[s]  = 1'b1;
    endtask

    // Advance to the first cycle where digit 0 is shown.
    task automatic sync_frame(input string name);
        logic [7:0] prev_an;
        logic       prev_tick;
        bit         found;
        prev_an   = an;
        prev_tick = scan_tick;
        found     = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (an == 8'hFE && prev_an != 8'hFE) begin
                found = 1'b1;
            end else begin
                prev_an   = an;
                prev_tick = scan_tick;
            end
        end
        sync_prev_tick = prev_tick;
        check({name, "_sync"}, {31'd0, found}, 32'd1);
    endtask

    // Compare 32 consecutive cycles against the expected slot table,
    // starting at the current (synced) cycle. Optionally change digits mid-frame.
    task automatic capture_frame(input string name, input int chg_cycle, input logic [31:0] new_digits);
        for (int k = 0; k < 32; k++) begin
            if (k > 0) @(negedge clk);
            if (k == chg_cycle) digits = new_digits;
            check($sformatf("%s_c%0d", name, k), {16'd0, an, seg, dp},
                  {16'd0, e_an[k/4], e_seg[k/4], e_dp[k/4]});
        end
    endtask

    initial begin
        int         pulses;
        int         bad_gap;
        int         last_pos;
        int         first_pos;
        bit         found;

        reset    = 1'b0;
        digits   = 32'h76543210;
        digit_en = 8'hFF;
        dp_mask  = 8'h00;
        blank_lz = 1'b0;

        // Reset state after a few clocks with reset held low.
        repeat (3) @(negedge clk);
        check("rst_an",   {24'd0, an},  32'h0000_00FF);
        check("rst_seg",  {25'd0, seg}, 32'h0000_007F);
        check("rst_dp",   {31'd0, dp},  32'd1);
        check("rst_tick", {31'd0, scan_tick}, 32'd0);
        reset = 1'b1;

        // Plain ascending digits, all lit.
        for (int s = 0; s < 8; s++) set_lit(s, 7'h00, 1'b1);
        e_seg[0] = S0; e_seg[1] = S1; e_seg[2] = S2; e_seg[3] = S3;
        e_seg[4] = S4; e_seg[5] = S5; e_seg[6] = S6; e_seg[7] = S7;
        sync_frame("plain");
        sync_frame("plain");
        capture_frame("plain", -1, 32'h0);

        // Leading-zero blanking of 00000420.
        digits   = 32'h00000420;
        blank_lz = 1'b1;
        set_lit(0, S0, 1'b1);
        set_lit(1, S2, 1'b1);
        set_lit(2, S4, 1'b1);
        for (int s = 3; s < 8; s++) set_dark(s);
        sync_frame("lz");
        sync_frame("lz");
        capture_frame("lz", -1, 32'h0);

        // All zeros with blanking: only digit 0 shows '0'.
        digits = 32'h00000000;
        set_lit(0, S0, 1'b1);
        for (int s = 1; s < 8; s++) set_dark(s);
        sync_frame("zero");
        sync_frame("zero");
        capture_frame("zero", -1, 32'h0);

        // Partial enable with a decimal point on digit 2.
        digits   = 32'h76543210;
        blank_lz = 1'b0;
        digit_en = 8'h0F;
        dp_mask  = 8'h04;
        set_lit(0, S0, 1'b1);
        set_lit(1, S1, 1'b1);
        set_lit(2, S2, 1'b0);
        set_lit(3, S3, 1'b1);
        for (int s = 4; s < 8; s++) set_dark(s);
        sync_frame("en");
        sync_frame("en");
        capture_frame("en", -1, 32'h0);

        // Snapshot hold: change digits during digit 3, frame must stay 1s.
        digits   = 32'h11111111;
        digit_en = 8'hFF;
        dp_mask  = 8'h00;
        for (int s = 0; s < 8; s++) set_lit(s, S1, 1'b1);
        sync_frame("hold");
        sync_frame("hold");
        capture_frame("hold", 13, 32'h22222222);
        for (int s = 0; s < 8; s++) set_lit(s, S2, 1'b1);
        sync_frame("next");
        capture_frame("next", -1, 32'h0);

        // scan_tick cadence over three frames.
        sync_frame("tick");
        check("tick_before_d0", {31'd0, sync_prev_tick}, 32'd1);
        check("tick_at_d0",     {31'd0, scan_tick},      32'd0);
        pulses    = 0;
        bad_gap   = 0;
        last_pos  = -1;
        first_pos = -1;
        for (int k = 1; k <= 96; k++) begin
            @(negedge clk);
            if (scan_tick) begin
                if (first_pos < 0) first_pos = k;
                if (last_pos >= 0 && (k - last_pos) != 4) bad_gap++;
                last_pos = k;
                pulses++;
            end
        end
        check("tick_count", pulses,    32'd24);
        check("tick_gaps",  bad_gap,   32'd0);
        check("tick_first", first_pos, 32'd3);

        // Reset asserted while digit 5 is displayed, between clock edges.
        digits = 32'h76543210;
        found  = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (an == 8'hDF) found = 1'b1;
        end
        check("d5_seen", {31'd0, found}, 32'd1);
        repeat (3) @(negedge clk);
        check("d5_last_an",   {24'd0, an}, 32'h0000_00DF);
        check("d5_last_tick", {31'd0, scan_tick}, 32'd1);
        #1 reset = 1'b0;
        #1;
        check("async_an",   {24'd0, an},  32'h0000_00FF);
        check("async_seg",  {25'd0, seg}, 32'h0000_007F);
        check("async_dp",   {31'd0, dp},  32'd1);
        check("async_tick", {31'd0, scan_tick}, 32'd0);
        digits = 32'h88888888;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (an != 8'hFF) found = 1'b1;
        end
        check("rel_lit",   {31'd0, found}, 32'd1);
        check("rel_an",    {24'd0, an},    32'h0000_00FE);
        check("rel_seg",   {25'd0, seg},   {25'd0, S8});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 Parameter: REFRESH_DIV, default 100000, clk cycles per digit slot; legal range >= 1.
REQ-002 Port: clk  in  1  single system clock; all state on rising edge.
REQ-003 Port: reset  in  1  asynchronous, active-low reset.
REQ-004 Port: digits  in  32  eight 4-bit digit values from the upstream counter chain; digit i = digits[4i+3:4i], digit 0 least significant.
REQ-005 Port: digit_en  in  8  per-digit enable; 0 = digit dark.
REQ-006 Port: dp_mask  in  8  per-digit decimal point request; 1 = point lit.
REQ-007 Port: blank_lz  in  1  leading-zero blanking enable.
REQ-008 Port: an  out  8  active-low anode selects; an[i] drives digit i.
REQ-009 Port: seg  out  7  active-low segments, order {g,f,e,d,c,b,a}.
REQ-010 Port: dp  out  1  active-low decimal point.
REQ-011 Port: scan_tick  out  1  one-cycle pulse per digit advance.

Function
REQ-012 Prescaler counts 0..REFRESH_DIV-1 and wraps; tick = prescaler at REFRESH_DIV-1.
REQ-013 REFRESH_DIV=1: tick every cycle.
REQ-014 Scan index 0..7 increments on each tick; 7 wraps to 0.
REQ-015 scan_tick is registered and high exactly in the cycle the scan index holds its new value.
REQ-016 Snapshot register holds digits, digit_en, dp_mask and blank_lz together.
REQ-017 Snapshot loads on the tick where index advances 7->0, and on the first clock edge after reset deasserts; otherwise it holds.
REQ-018 Input changes between snapshot loads have no effect on the outputs.
REQ-019 an/seg/dp are registered, computed from current index and snapshot, with one-cycle latency.
REQ-020 Active digit shown: an = one-hot-low at index, seg = decode of the snapshot digit, dp = ~dp_mask[index].
REQ-021 Decode, hex 0-F, {g..a} active-low:
  - 0=1000000  1=1111001  2=0100100  3=0110000
  - 4=0011001  5=0010010  6=0000010  7=1111000
  - 8=0000000  9=0010000  A=0001000  b=0000011
  - C=1000110  d=0100001  E=0000110  F=0001110
REQ-022 Digit i is blanked when blank_lz=1, i!=0, and snapshot digits i..7 are all zero.
REQ-023 Digit 0 is never blanked by leading-zero logic.
REQ-024 Dark slot: for a blanked digit, or digit_en[index]=0, the slot outputs an=8'hFF, seg=7'h7F, dp=1; timing is unaffected.
REQ-025 At most one an bit is low in any cycle.

Reset
REQ-026 While reset=0, immediately and independent of clk:
  - prescaler=0, index=0, snapshot=0, load flag set
  - an=8'hFF, seg=7'h7F, dp=1, scan_tick=0
REQ-027 Reset asserted mid-scan aborts the frame; after release, scanning restarts at digit 0 with a fresh snapshot per REQ-017.

Verification (REFRESH_DIV=4)
REQ-028 Reset pulse during digit 5:
  - outputs go FF/7F/1, scan_tick=0 without a clock edge
  - after release, first lit anode is an=8'hFE
REQ-029 digits=32'h76543210, digit_en=FF, dp_mask=00, blank_lz=0:
  - an steps FE,FD,FB,F7,EF,DF,BF,7F, each held 4 cycles
  - seg for digit 0 = 1000000, for digit 7 = 1111000; dp=1 throughout
REQ-030 Leading-zero blanking:
  - digits=32'h00000420, blank_lz=1: digits 3-7 dark; digit 2 seg=0011001, digit 1 seg=0100100, digit 0 seg=1000000
  - digits all zero, blank_lz=1: only digit 0 lit, shown as '0'
REQ-031 Snapshot hold: change digits from 32'h11111111 to 32'h22222222 during digit 3:
  - digits 4-7 still show 1111001
  - next frame shows 0100100
REQ-032 digit_en=8'h0F, dp_mask=8'h04:
  - an never low for bits 4-7
  - dp=0 only while an=8'hFB
REQ-033 scan_tick: 8 pulses per 32-cycle frame, spaced exactly 4 cycles; prescaler wrap confirmed over 3 frames.
